// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU op codes, exception codes,
// memory/control NOP codes and the multiply/divide FSM state encoding.
package ex_stage_pkg;

  localparam int ALU_OP_BUS = 4;
  typedef logic [ALU_OP_BUS-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_NOP  = 4'd0;
  localparam alu_op_t ALU_OP_AND  = 4'd1;
  localparam alu_op_t ALU_OP_OR   = 4'd2;
  localparam alu_op_t ALU_OP_XOR  = 4'd3;
  localparam alu_op_t ALU_OP_ADDS = 4'd4;
  localparam alu_op_t ALU_OP_ADDU = 4'd5;
  localparam alu_op_t ALU_OP_SUBS = 4'd6;
  localparam alu_op_t ALU_OP_SUBU = 4'd7;
  localparam alu_op_t ALU_OP_SHRL = 4'd8;
  localparam alu_op_t ALU_OP_SHLL = 4'd9;
  localparam alu_op_t ALU_OP_MUL  = 4'd10;
  localparam alu_op_t ALU_OP_DIVU = 4'd11;
  localparam alu_op_t ALU_OP_REMU = 4'd12;

  localparam logic [2:0] ISA_EXP_NO_EXP   = 3'd0;
  localparam logic [2:0] ISA_EXP_OVERFLOW = 3'd3;

  localparam logic [1:0] MEM_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_NOP = 2'd0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // True for the ops executed by the iterative multiply/divide unit.
  function automatic logic is_muldiv(input alu_op_t op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID -> EX instruction bundle. The decode stage drives it (master), the
// execute stage consumes it (slave).
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [29:0] IDPC;
  logic        IDEn;
  alu_op_t     IDAluOp;
  logic [31:0] IDAluIn0;
  logic [31:0] IDAluIn1;
  logic        IDBrFlag;
  logic [1:0]  IDMemOp;
  logic [31:0] IDMemWrData;
  logic [1:0]  IDCtrlOp;
  logic [4:0]  IDDstAddr;
  logic        IDGPRWE_;
  logic [2:0]  IDExpCode;

  modport master (
    output IDPC, IDEn, IDAluOp, IDAluIn0, IDAluIn1, IDBrFlag, IDMemOp,
           IDMemWrData, IDCtrlOp, IDDstAddr, IDGPRWE_, IDExpCode
  );

  modport slave (
    input  IDPC, IDEn, IDAluOp, IDAluIn0, IDAluIn1, IDBrFlag, IDMemOp,
           IDMemWrData, IDCtrlOp, IDDstAddr, IDGPRWE_, IDExpCode
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-bit unsigned multiply / divide unit. One shift-add (MUL) or
// restoring-subtract (DIVU/REMU) step per RUN cycle; divide by zero skips RUN.
// Three shared registers: acc (product accumulator / partial remainder),
// sh (multiplier / dividend-then-quotient) and opd (multiplicand / divisor).
module ex_muldiv
  import ex_stage_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        start_i,
  input  alu_op_t     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam int               CNT_W    = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  alu_op_t          op_q;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      opd_q, opd_d;
  logic [32:0]      rem_sh;
  logic             div_zero;
  logic             issue;

  assign div_zero = (op_i != ALU_OP_MUL) && (b_i == '0);
  assign issue    = (state_q == MD_IDLE) && start_i && !flush_i;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= MD_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush always wins and drops any partial result.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (start_i) state_d = div_zero ? MD_DONE : MD_RUN;
        MD_RUN:  if (cnt_q == '0) state_d = MD_DONE;
        MD_DONE: if (!stall_i) state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // Outputs: busy covers the issue cycle and every RUN cycle.
  always_comb begin
    busy_o   = ((state_q == MD_IDLE) && start_i) || (state_q == MD_RUN);
    done_o   = (state_q == MD_DONE);
    result_o = '0;
    if (state_q == MD_DONE) result_o = (op_q == ALU_OP_DIVU) ? sh_q : acc_q;
  end

  // One iteration of the selected algorithm.
  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    opd_d  = opd_q;
    rem_sh = {acc_q, sh_q[31]};
    if (op_q == ALU_OP_MUL) begin
      acc_d = sh_q[0] ? (acc_q + opd_q) : acc_q;
      sh_d  = sh_q >> 1;
      opd_d = opd_q << 1;
    end else if (rem_sh >= {1'b0, opd_q}) begin
      acc_d = 32'(rem_sh - {1'b0, opd_q});
      sh_d  = {sh_q[30:0], 1'b1};
    end else begin
      acc_d = rem_sh[31:0];
      sh_d  = {sh_q[30:0], 1'b0};
    end
  end

  // Datapath: load operands on issue, step while running.
  // Divide by zero preloads the final answer (all-ones quotient, dividend as remainder).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= ALU_OP_NOP;
      acc_q <= '0;
      sh_q  <= '0;
      opd_q <= '0;
    end else if (issue) begin
      op_q  <= op_i;
      cnt_q <= CNT_LAST;
      if (op_i == ALU_OP_MUL) begin
        acc_q <= '0;
        sh_q  <= b_i;
        opd_q <= a_i;
      end else if (div_zero) begin
        acc_q <= a_i;
        sh_q  <= '1;
        opd_q <= '0;
      end else begin
        acc_q <= '0;
        sh_q  <= a_i;
        opd_q <= b_i;
      end
    end else if (state_q == MD_RUN) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opd_q <= opd_d;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with signed-overflow detection, iterative
// multiply/divide, and the EX/MEM pipeline register feeding mem_stage.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  output logic        Busy,
  ex_stage_if.slave   id_bus,
  output logic [31:0] EXFwdData,
  output logic [29:0] EXPC,
  output logic        EXEn,
  output logic        EXBrFlag,
  output logic [1:0]  EXMemOp,
  output logic [31:0] EXMemWrData,
  output logic [1:0]  EXCtrlOp,
  output logic [4:0]  EXDstAddr,
  output logic        EXGPRWE_,
  output logic [2:0]  EXExpCode,
  output logic [31:0] EXOut
);

  logic [31:0] alu_a, alu_b, alu_sum, alu_diff, alu_res;
  logic        ovf;
  logic        md_start, md_busy, md_done;
  logic [31:0] md_result;

  // EX/MEM register and its load values.
  logic [29:0] pc_q,     pc_d;
  logic        en_q,     en_d;
  logic        br_q,     br_d;
  logic [1:0]  memop_q,  memop_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [1:0]  ctrl_q,   ctrl_d;
  logic [4:0]  dst_q,    dst_d;
  logic        gprwe_q,  gprwe_d;
  logic [2:0]  exp_q,    exp_d;
  logic [31:0] out_q,    out_d;

  assign alu_a    = id_bus.IDAluIn0;
  assign alu_b    = id_bus.IDAluIn1;
  assign alu_sum  = alu_a + alu_b;
  assign alu_diff = alu_a - alu_b;

  // Single-cycle ALU; mul/div codes yield 0 here and are supplied by ex_muldiv.
  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (id_bus.IDAluOp)
      ALU_OP_AND:  alu_res = alu_a & alu_b;
      ALU_OP_OR:   alu_res = alu_a | alu_b;
      ALU_OP_XOR:  alu_res = alu_a ^ alu_b;
      ALU_OP_ADDS: begin
        alu_res = alu_sum;
        ovf     = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      ALU_OP_ADDU: alu_res = alu_sum;
      ALU_OP_SUBS: begin
        alu_res = alu_diff;
        ovf     = (alu_a[31] != alu_b[31]) && (alu_diff[31] != alu_a[31]);
      end
      ALU_OP_SUBU: alu_res = alu_diff;
      ALU_OP_SHRL: alu_res = alu_a >> alu_b[4:0];
      ALU_OP_SHLL: alu_res = alu_a << alu_b[4:0];
      default:     alu_res = '0;
    endcase
  end

  // A faulting instruction must not start the mul/div unit.
  assign md_start = is_muldiv(id_bus.IDAluOp) && id_bus.IDEn &&
                    (id_bus.IDExpCode == ISA_EXP_NO_EXP);

  ex_muldiv #(
    .MD_ITER (MD_ITER)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (Flush),
    .stall_i  (Stall),
    .start_i  (md_start),
    .op_i     (id_bus.IDAluOp),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign Busy      = md_busy;
  assign EXFwdData = md_done ? md_result : alu_res;

  // Values loaded into EX/MEM: bubble while busy or invalid, otherwise the
  // instruction with write-back and memory access suppressed on any exception.
  always_comb begin
    pc_d     = id_bus.IDPC;
    br_d     = id_bus.IDBrFlag;
    wrdata_d = id_bus.IDMemWrData;
    dst_d    = id_bus.IDDstAddr;
    out_d    = EXFwdData;
    en_d     = id_bus.IDEn;
    gprwe_d  = id_bus.IDGPRWE_;
    memop_d  = id_bus.IDMemOp;
    ctrl_d   = id_bus.IDCtrlOp;
    exp_d    = id_bus.IDExpCode;
    if (md_busy || !id_bus.IDEn) begin
      en_d    = 1'b0;
      gprwe_d = 1'b1;
      memop_d = MEM_OP_NOP;
      ctrl_d  = CTRL_OP_NOP;
      exp_d   = ISA_EXP_NO_EXP;
    end else if (id_bus.IDExpCode != ISA_EXP_NO_EXP) begin
      gprwe_d = 1'b1;
      memop_d = MEM_OP_NOP;
    end else if (ovf) begin
      exp_d   = ISA_EXP_OVERFLOW;
      gprwe_d = 1'b1;
      memop_d = MEM_OP_NOP;
    end
  end

  // EX/MEM register: reset/flush clear to a bubble, stall holds, else load.
  always_ff @(posedge clk) begin
    if (reset || Flush) begin
      pc_q     <= '0;
      en_q     <= 1'b0;
      br_q     <= 1'b0;
      memop_q  <= MEM_OP_NOP;
      wrdata_q <= '0;
      ctrl_q   <= CTRL_OP_NOP;
      dst_q    <= '0;
      gprwe_q  <= 1'b1;
      exp_q    <= ISA_EXP_NO_EXP;
      out_q    <= '0;
    end else if (!Stall) begin
      pc_q     <= pc_d;
      en_q     <= en_d;
      br_q     <= br_d;
      memop_q  <= memop_d;
      wrdata_q <= wrdata_d;
      ctrl_q   <= ctrl_d;
      dst_q    <= dst_d;
      gprwe_q  <= gprwe_d;
      exp_q    <= exp_d;
      out_q    <= out_d;
    end
  end

  assign EXPC        = pc_q;
  assign EXEn        = en_q;
  assign EXBrFlag    = br_q;
  assign EXMemOp     = memop_q;
  assign EXMemWrData = wrdata_q;
  assign EXCtrlOp    = ctrl_q;
  assign EXDstAddr   = dst_q;
  assign EXGPRWE_    = gprwe_q;
  assign EXExpCode   = exp_q;
  assign EXOut       = out_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of single-cycle ALU vectors plus hand-written
// mul/div, flush, stall and reset sequences. Expected EX/MEM contents are
// queued when an instruction is driven and popped whenever EXEn rises.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush, Busy;
  logic [31:0] EXFwdData, EXMemWrData, EXOut;
  logic [29:0] EXPC;
  logic        EXEn, EXBrFlag, EXGPRWE_;
  logic [1:0]  EXMemOp, EXCtrlOp;
  logic [4:0]  EXDstAddr;
  logic [2:0]  EXExpCode;

  ex_stage_if id_bus();

  ex_stage #(.MD_ITER(32)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .Busy(Busy),
    .id_bus(id_bus), .EXFwdData(EXFwdData), .EXPC(EXPC), .EXEn(EXEn),
    .EXBrFlag(EXBrFlag), .EXMemOp(EXMemOp), .EXMemWrData(EXMemWrData),
    .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr), .EXGPRWE_(EXGPRWE_),
    .EXExpCode(EXExpCode), .EXOut(EXOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic [2:0]  expc;
    logic        gprwe_n;
    logic [1:0]  mem;
    logic [29:0] pc;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        gprwe_n;
    logic [2:0]  exp_in;
    logic [1:0]  mem_in;
    logic [31:0] out;
    logic [2:0]  exp_out;
    logic        gprwe_out;
    logic [1:0]  mem_out;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic gprwe_n, input logic [2:0] expc,
                       input logic [1:0] mem, input logic [29:0] pc);
    id_bus.IDAluOp     = op;
    id_bus.IDAluIn0    = a;
    id_bus.IDAluIn1    = b;
    id_bus.IDEn        = en;
    id_bus.IDGPRWE_    = gprwe_n;
    id_bus.IDExpCode   = expc;
    id_bus.IDMemOp     = mem;
    id_bus.IDPC        = pc;
    id_bus.IDCtrlOp    = 2'd2;
    id_bus.IDDstAddr   = pc[4:0];
    id_bus.IDBrFlag    = pc[0];
    id_bus.IDMemWrData = 32'hCAFE_0000 | 32'(pc[15:0]);
  endtask

  task automatic idle();
    drive(ALU_OP_NOP, 32'h0, 32'h0, 1'b0, 1'b1, 3'd0, 2'd0, 30'h0);
  endtask

  task automatic push(input logic [31:0] out, input logic [2:0] expc, input logic gprwe_n,
                      input logic [1:0] mem, input logic [29:0] pc);
    exp_t e;
    e.out = out; e.expc = expc; e.gprwe_n = gprwe_n; e.mem = mem; e.pc = pc;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every valid EX/MEM load must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (EXEn === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got EXOut=%h EXPC=%h want no valid output", EXOut, EXPC);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("exout", EXOut, e.out);
        chk("expcode", 32'(EXExpCode), 32'(e.expc));
        chk("gprwe_n", 32'(EXGPRWE_), 32'(e.gprwe_n));
        chk("memop", 32'(EXMemOp), 32'(e.mem));
        chk("ctrlop", 32'(EXCtrlOp), 32'd2);
        chk("pc", 32'(EXPC), 32'(e.pc));
        chk("dst_br", 32'({EXDstAddr, EXBrFlag}), 32'({e.pc[4:0], e.pc[0]}));
        chk("wrdata", EXMemWrData, 32'hCAFE_0000 | 32'(e.pc[15:0]));
        $display("txn pc=%h out=%h exp=%0d gprwe_n=%0d mem=%0d", EXPC, EXOut, EXExpCode, EXGPRWE_, EXMemOp);
      end
    end
  end

  // Issue a mul/div op, count edges until its result is loaded and Busy cycles on the way.
  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int want_edges,
                        input int want_busy, input logic [29:0] pc);
    int   edges  = 0;
    int   busy_n = 0;
    logic got    = 1'b0;
    @(negedge clk);
    drive(op, a, b, 1'b1, 1'b0, 3'd0, 2'd1, pc);
    push(want, 3'd0, 1'b0, 2'd1, pc);
    while (!got && edges < 60) begin
      #2;
      if (Busy === 1'b1) busy_n++;
      @(posedge clk);
      edges++;
      #1;
      if (EXEn === 1'b1) got = 1'b1;
    end
    chk({name, "_edges"}, 32'(edges), 32'(want_edges));
    chk({name, "_busy_cycles"}, 32'(busy_n), 32'(want_busy));
    @(negedge clk);
    idle();
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    idle();

    vecs[0]  = '{ALU_OP_ADDU, 32'hFFFF_FFFF, 32'h1,         1'b0, 3'd0, 2'd1, 32'h0,         3'd0, 1'b0, 2'd1};
    vecs[1]  = '{ALU_OP_ADDS, 32'h7FFF_FFFF, 32'h1,         1'b0, 3'd0, 2'd2, 32'h8000_0000, 3'd3, 1'b1, 2'd0};
    vecs[2]  = '{ALU_OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 3'd0, 2'd1, 32'h00F0_1234, 3'd0, 1'b0, 2'd1};
    vecs[3]  = '{ALU_OP_OR,   32'h0F00_0000, 32'h0000_00F0, 1'b1, 3'd0, 2'd3, 32'h0F00_00F0, 3'd0, 1'b1, 2'd3};
    vecs[4]  = '{ALU_OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 3'd0, 2'd0, 32'hF0F0_0F0F, 3'd0, 1'b0, 2'd0};
    vecs[5]  = '{ALU_OP_SUBU, 32'h5,         32'h7,         1'b0, 3'd0, 2'd1, 32'hFFFF_FFFE, 3'd0, 1'b0, 2'd1};
    vecs[6]  = '{ALU_OP_SUBS, 32'h8000_0000, 32'h1,         1'b0, 3'd0, 2'd2, 32'h7FFF_FFFF, 3'd3, 1'b1, 2'd0};
    vecs[7]  = '{ALU_OP_SUBS, 32'h5,         32'h7,         1'b0, 3'd0, 2'd2, 32'hFFFF_FFFE, 3'd0, 1'b0, 2'd2};
    vecs[8]  = '{ALU_OP_SHRL, 32'h8000_0000, 32'h3F,        1'b0, 3'd0, 2'd0, 32'h1,         3'd0, 1'b0, 2'd0};
    vecs[9]  = '{ALU_OP_SHLL, 32'h1,         32'h24,        1'b0, 3'd0, 2'd0, 32'h10,        3'd0, 1'b0, 2'd0};
    vecs[10] = '{ALU_OP_NOP,  32'h5,         32'h6,         1'b0, 3'd0, 2'd1, 32'h0,         3'd0, 1'b0, 2'd1};
    vecs[11] = '{4'd14,       32'h5,         32'h6,         1'b0, 3'd0, 2'd0, 32'h0,         3'd0, 1'b0, 2'd0};
    vecs[12] = '{ALU_OP_ADDS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd1, 32'hFFFF_FFFE, 3'd0, 1'b0, 2'd1};
    vecs[13] = '{ALU_OP_ADDU, 32'h1,         32'h2,         1'b0, 3'd2, 2'd1, 32'h3,         3'd2, 1'b1, 2'd0};
    vecs[14] = '{ALU_OP_ADDS, 32'h8000_0000, 32'h8000_0000, 1'b0, 3'd0, 2'd3, 32'h0,         3'd3, 1'b1, 2'd0};
    vecs[15] = '{ALU_OP_SUBS, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'd0, 2'd1, 32'h8000_0000, 3'd3, 1'b1, 2'd0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(EXEn), 32'd0);
    chk("rst_gprwe_n", 32'(EXGPRWE_), 32'd1);
    chk("rst_out", EXOut, 32'h0);
    chk("rst_exp", 32'(EXExpCode), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    reset = 1'b0;

    // Single-cycle ALU table, back to back.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].gprwe_n, vecs[i].exp_in,
            vecs[i].mem_in, 30'(i + 16));
      push(vecs[i].out, vecs[i].exp_out, vecs[i].gprwe_out, vecs[i].mem_out, 30'(i + 16));
    end

    // IDEn=0 loads a bubble but still carries the PC.
    @(negedge clk);
    drive(ALU_OP_ADDU, 32'h1, 32'h1, 1'b0, 1'b0, 3'd0, 2'd1, 30'h123);
    @(posedge clk); #1;
    chk("bubble_en", 32'(EXEn), 32'd0);
    chk("bubble_gprwe_n", 32'(EXGPRWE_), 32'd1);
    chk("bubble_memop", 32'(EXMemOp), 32'd0);
    chk("bubble_pc", 32'(EXPC), 32'h123);

    // A mul op carrying an exception must not start the unit.
    @(negedge clk);
    drive(ALU_OP_MUL, 32'h3, 32'h4, 1'b1, 1'b0, 3'd1, 2'd1, 30'h40);
    #2;
    chk("exc_no_start_busy", 32'(Busy), 32'd0);
    idle();

    run_md("mul",    ALU_OP_MUL,  32'h0001_0003, 32'h5, 32'h0005_000F, 34, 33, 30'h41);
    run_md("divu",   ALU_OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 33, 30'h42);
    run_md("remu",   ALU_OP_REMU, 32'd100, 32'd7, 32'd2,  34, 33, 30'h43);
    run_md("divu0",  ALU_OP_DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF, 2, 1, 30'h44);
    run_md("remu0",  ALU_OP_REMU, 32'd5,   32'd0, 32'd5,  2, 1, 30'h45);

    // Flush during RUN cycle 10 of a DIVU, then an ADDU completes normally.
    @(negedge clk);
    drive(ALU_OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 3'd0, 2'd1, 30'h50);
    repeat (10) @(posedge clk);
    @(negedge clk);
    Flush = 1'b1;
    idle();
    @(posedge clk); #1;
    chk("flush_busy", 32'(Busy), 32'd0);
    chk("flush_en", 32'(EXEn), 32'd0);
    chk("flush_gprwe_n", 32'(EXGPRWE_), 32'd1);
    chk("flush_out", EXOut, 32'h0);
    chk("flush_pc", 32'(EXPC), 32'h0);
    @(negedge clk);
    Flush = 1'b0;
    drive(ALU_OP_ADDU, 32'd3, 32'd4, 1'b1, 1'b0, 3'd0, 2'd1, 30'h51);
    push(32'd7, 3'd0, 1'b0, 2'd1, 30'h51);
    #1;
    chk("post_flush_busy", 32'(Busy), 32'd0);
    @(posedge clk); #1;
    chk("post_flush_en", 32'(EXEn), 32'd1);
    @(negedge clk);
    idle();

    // Stall held for 3 cycles in DONE, then released.
    @(negedge clk);
    drive(ALU_OP_MUL, 32'd3, 32'd4, 1'b1, 1'b0, 3'd0, 2'd1, 30'h60);
    push(32'd12, 3'd0, 1'b0, 2'd1, 30'h60);
    repeat (33) @(posedge clk);
    @(negedge clk);
    Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("stall_busy", 32'(Busy), 32'd0);
      chk("stall_en", 32'(EXEn), 32'd0);
      chk("stall_fwd", EXFwdData, 32'd12);
    end
    @(negedge clk);
    Stall = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_en", 32'(EXEn), 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("stall_idle_busy", 32'(Busy), 32'd0);
    chk("stall_idle_fwd", EXFwdData, 32'd0);
    @(posedge clk); #1;
    chk("stall_once_en", 32'(EXEn), 32'd0);

    // Reset in the middle of a MUL.
    @(negedge clk);
    drive(ALU_OP_MUL, 32'd7, 32'd9, 1'b1, 1'b0, 3'd0, 2'd1, 30'h70);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_en", 32'(EXEn), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_md("mul_max", ALU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 34, 33, 30'h71);

    @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
